dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port synchronous data memory between the core's MEM stage and a debug/loader port. Each cycle it grants at most one requester, with core priority bounded by a starvation counter. It stalls the core when the core loses arbitration and handles byte/half/word lane alignment for core accesses. Read data returns one cycle after issue, aligned with the WB stage.

## Interface
- STARVE_LIMIT, 4: consecutive core wins while debug waits before debug is forced a grant (1..15)
- ADDR_W, DATA_MEM_ADDR_WIDTH: word-address width toward memory
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  MEM-stage access (MemRead | MemWrite)
- core_we_i  in  1  1 = store
- core_addr_i  in  32  byte address (alu_result)
- core_wdata_i  in  32  store data (rd_data2), LSB-justified
- core_funct3_i  in  3  access size/sign (FUNCT3_LOAD_*/FUNCT3_STORE_*)
- core_stall_o  out  1  core request not granted this cycle
- core_misalign_o  out  1  core request misaligned, dropped
- core_rvalid_o  out  1  load data valid (WB cycle)
- core_rdata_o  out  32  extended load data
- dbg_valid_i  in  1  debug request valid
- dbg_ready_o  out  1  debug request accepted this cycle
- dbg_we_i  in  1  1 = word write
- dbg_addr_i  in  32  byte address, bits [1:0] ignored
- dbg_wdata_i  in  32  write word
- dbg_rvalid_o  out  1  debug read data valid
- dbg_rdata_o  out  32  raw read word
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  4  byte write enables
- mem_addr_o  out  ADDR_W  word index = addr[ADDR_W+1:2]
- mem_wdata_o  out  32  lane-replicated write data
- mem_rdata_i  in  32  read word, valid one cycle after mem_en_o

## Operation
- Core request is valid when core_req_i is high and the access is aligned. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. A misaligned request sets core_misalign_o=1, is never issued, does not stall, and produces no rvalid.
- Arbitration (combinational) selects grant ∈ {NONE, CORE, DBG}:
  - Only one valid requester: that requester is granted.
  - Both valid: CORE wins, unless starve_cnt == STARVE_LIMIT, in which case DBG wins.
- starve_cnt update:
  - +1 when CORE wins while dbg_valid_i=1.
  - Cleared on a DBG grant or whenever dbg_valid_i=0.
  - Saturates at STARVE_LIMIT.
- core_stall_o = valid core request & grant≠CORE. dbg_ready_o = (grant==DBG). Debug must hold its request until ready.
- Stores:
  - Byte: mem_we_o = 4'b0001<<addr[1:0], data replicated ×4.
  - Half: mem_we_o = 4'b0011<<addr[1:0], data replicated ×2.
  - Word: mem_we_o = 4'hF.
  - Debug writes: mem_we_o = 4'hF.
- Reads: at issue, register owner, funct3 and addr[1:0]. The next cycle, assert the owner's rvalid. Core data is the selected lane, sign- or zero-extended per funct3. Debug data is the raw word.
- When no grant: mem_en_o=0, mem_we_o=0. Address and data outputs are don't-care; drive them 0.

## Timing
- Grant, stall, ready and all mem_* outputs are combinational from the current inputs plus starve_cnt. Zero cycles request-to-memory.
- Read latency is 1 cycle: rvalid is a single-cycle pulse in the cycle after issue. Back-to-back reads give back-to-back rvalid pulses.
- Core_rdata_o and dbg_rdata_o are 0 whenever the corresponding rvalid is 0.
- Reset values: starve_cnt=0, rvalid registers=0, captured funct3/offset=0. All outputs are 0 while rst_n=0.
- Reset asserted with a read outstanding: the response is discarded. No rvalid follows reset release.
- A write has no response. A write and a read in consecutive cycles are independent.
- With a stalled core and STARVE_LIMIT reached, debug is granted for exactly one cycle. The counter then clears and core priority resumes.

## Structure
- core_pkg additions:
  - typedef enum logic [1:0] dmem_gnt_e {GNT_NONE, GNT_CORE, GNT_DBG}.
  - localparam DMEM_STARVE_LIMIT = 4.
  - Reuses the FUNCT3_LOAD_*/FUNCT3_STORE_* constants and DATA_MEM_ADDR_WIDTH.
- Sub-module dmem_lane_align (combinational): store byte-enable/data replication and load lane extract/extend. The arbiter holds only the grant logic, starve_cnt and the response registers.

## Test plan
- Core SW 0xDEADBEEF @0x10, then LW @0x10 → mem_we_o=F, word index 4; the cycle after the load, core_rvalid_o=1, core_rdata_o=0xDEADBEEF.
- Core SB 0x80 @0x13, then LB and LBU @0x13 → mem_we_o=4'b1000; rdata 0xFFFFFF80, then 0x00000080.
- Core LH @0x11 → core_misalign_o=1, mem_en_o=0, no stall, no rvalid.
- Core and debug requesting continuously with STARVE_LIMIT=4 → grants repeat CORE×4, DBG×1. core_stall_o=1 only in the DBG cycles. dbg_ready_o pulses every 5th cycle.
- Debug read @0x20 with the core idle → dbg_ready_o=1 in the same cycle; dbg_rvalid_o=1 next cycle with the raw word; core_rvalid_o stays 0.
- Core LW issued, rst_n asserted low the next cycle → no core_rvalid_o and starve_cnt=0 after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam int unsigned DATA_MEM_ADDR_WIDTH = 10;
    localparam int unsigned DMEM_STARVE_LIMIT   = 4;

    localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

    // Access size lives in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_B = FUNCT3_STORE_SB[1:0];
    localparam logic [1:0] SIZE_H = FUNCT3_STORE_SH[1:0];
    localparam logic [1:0] SIZE_W = FUNCT3_STORE_SW[1:0];

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_DBG
    } dmem_gnt_e;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/replication and load lane extract/extend
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shift;

    always_comb begin
        st_be_o    = 4'hF;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SIZE_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SIZE_H: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            FUNCT3_LOAD_LB:  ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
            FUNCT3_LOAD_LH:  ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
            FUNCT3_LOAD_LBU: ld_data_o = {24'h0, ld_shift[7:0]};
            FUNCT3_LOAD_LHU: ld_data_o = {16'h0, ld_shift[15:0]};
            default:         ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter in front of the single-port data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DMEM_STARVE_LIMIT,
    parameter int unsigned ADDR_W       = DATA_MEM_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_wdata_i,
    input  logic [2:0]        core_funct3_i,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              core_rvalid_o,
    output logic [31:0]       core_rdata_o,
    input  logic              dbg_valid_i,
    output logic              dbg_ready_o,
    input  logic              dbg_we_i,
    input  logic [31:0]       dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    output logic              dbg_rvalid_o,
    output logic [31:0]       dbg_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    dmem_gnt_e   gnt;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic        dbg_rvalid_q, dbg_rvalid_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        misaligned, core_active, core_vld, dbg_vld;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;
    logic        unused_addr_bits;

    // Combinational outputs are gated by rst_n so everything reads 0 in reset.
    assign misaligned = ((core_funct3_i[1:0] == SIZE_H) && core_addr_i[0])
                      || (core_funct3_i[1] && (core_addr_i[1:0] != 2'b00));
    assign core_active     = rst_n && core_req_i;
    assign core_misalign_o = core_active && misaligned;
    assign core_vld        = core_active && !misaligned;
    assign dbg_vld         = rst_n && dbg_valid_i;

    always_comb begin
        gnt = GNT_NONE;
        if (core_vld && dbg_vld) begin
            gnt = (starve_cnt_q == LIMIT) ? GNT_DBG : GNT_CORE;
        end else if (core_vld) begin
            gnt = GNT_CORE;
        end else if (dbg_vld) begin
            gnt = GNT_DBG;
        end
    end

    assign core_stall_o = core_vld && (gnt != GNT_CORE);
    assign dbg_ready_o  = (gnt == GNT_DBG);

    dmem_lane_align u_lane_align (
        .st_size_i   (core_funct3_i[1:0]),
        .st_off_i    (core_addr_i[1:0]),
        .st_wdata_i  (core_wdata_i),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (mem_rdata_i),
        .ld_data_o   (ld_data)
    );

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        case (gnt)
            GNT_CORE: begin
                mem_en_o    = 1'b1;
                mem_we_o    = core_we_i ? st_be : 4'h0;
                mem_addr_o  = core_addr_i[ADDR_W+1:2];
                mem_wdata_o = st_wdata;
            end
            GNT_DBG: begin
                mem_en_o    = 1'b1;
                mem_we_o    = dbg_we_i ? 4'hF : 4'h0;
                mem_addr_o  = dbg_addr_i[ADDR_W+1:2];
                mem_wdata_o = dbg_wdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        core_rvalid_d = (gnt == GNT_CORE) && !core_we_i;
        dbg_rvalid_d  = (gnt == GNT_DBG) && !dbg_we_i;
        funct3_d      = funct3_q;
        off_d         = off_q;
        if (!dbg_valid_i || (gnt == GNT_DBG)) begin
            starve_cnt_d = 4'h0;
        end else if ((gnt == GNT_CORE) && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'h1;
        end
        if (core_rvalid_d) begin
            funct3_d = core_funct3_i;
            off_d    = core_addr_i[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q  <= 4'h0;
            core_rvalid_q <= 1'b0;
            dbg_rvalid_q  <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            core_rvalid_q <= core_rvalid_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rvalid_q ? ld_data : 32'h0;
    assign dbg_rvalid_o  = dbg_rvalid_q;
    assign dbg_rdata_o   = dbg_rvalid_q ? mem_rdata_i : 32'h0;

    assign unused_addr_bits = ^{core_addr_i[31:ADDR_W+2], dbg_addr_i[31:ADDR_W+2],
                                dbg_addr_i[1:0]};

endmodule
